// File: rtl/bcharger_nch_if.sv
// rtl/bcharger_nch_if.sv - control/status bundle for the multi-channel charger
// Purpose: groups the per-channel enables, raw comparator inputs and the
//   registered one-hot state indications so they travel as one port.
// Signals (NCH bits each):
//   en, vtrkl, vterm, iterm, vrchrg, fault_clr - toward the charger
//   trkl, fast, vconst, done, fault            - from the charger
// Modports: master drives the inputs (system side), slave is the charger.
interface bcharger_nch_if #(
  parameter int NCH = 2
) ();
  logic [NCH-1:0] en;
  logic [NCH-1:0] vtrkl;
  logic [NCH-1:0] vterm;
  logic [NCH-1:0] iterm;
  logic [NCH-1:0] vrchrg;
  logic [NCH-1:0] fault_clr;
  logic [NCH-1:0] trkl;
  logic [NCH-1:0] fast;
  logic [NCH-1:0] vconst;
  logic [NCH-1:0] done;
  logic [NCH-1:0] fault;

  modport master (
    output en, vtrkl, vterm, iterm, vrchrg, fault_clr,
    input  trkl, fast, vconst, done, fault
  );

  modport slave (
    input  en, vtrkl, vterm, iterm, vrchrg, fault_clr,
    output trkl, fast, vconst, done, fault
  );
endinterface

// File: rtl/bcharger_nch.sv
// rtl/bcharger_nch.sv - multi-channel battery charger state controller
// Purpose: per-channel charge sequencing IDLE/TRKL/FAST/VCONST/DONE/FAULT,
//   driven by 2-flop synchronized and debounced comparator inputs.
// Ports:
//   clk   - clock, all state updates on the rising edge
//   reset - asynchronous, active-high
//   bus   - bcharger_nch_if.slave: en, vtrkl, vterm, iterm, vrchrg, fault_clr
//           in; trkl, fast, vconst, done, fault out (registered, one-hot)
// Option: define BCHARGER_NCH_SAFETY_TIMER_EN to build the per-channel safety
//   timers and the sticky FAULT state; without it fault is tied to 0.
module bcharger_nch #(
  parameter int NCH   = 2,
  parameter int DEB   = 3,
  parameter int T_MAX = 1000,
  parameter int TMR_W = 16
) (
  input  logic          clk,
  input  logic          reset,
  bcharger_nch_if.slave bus
);
  localparam int NB = 4 * NCH;
  localparam int CW = $clog2(DEB + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_TRKL   = 3'd1,
    S_FAST   = 3'd2,
    S_VCONST = 3'd3,
    S_DONE   = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  // Comparator bits packed as {vrchrg, iterm, vterm, vtrkl}, NCH bits each.
  logic [NB-1:0]  w_raw;
  logic [NB-1:0]  r_sync1;
  logic [NB-1:0]  r_sync2;
  logic [NB-1:0]  r_filt;
  logic [CW-1:0]  r_cnt [NB];
  logic [NCH-1:0] w_vtrkl_f;
  logic [NCH-1:0] w_vterm_f;
  logic [NCH-1:0] w_iterm_f;
  logic [NCH-1:0] w_vrchrg_f;

  assign w_raw = {bus.vrchrg, bus.iterm, bus.vterm, bus.vtrkl};

  // The count tracks consecutive cycles where the synchronized bit disagrees
  // with the filtered bit; any agreement restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_filt  <= '0;
      for (int b = 0; b < NB; b++) r_cnt[b] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int b = 0; b < NB; b++) begin
        if (r_sync2[b] == r_filt[b]) begin
          r_cnt[b] <= '0;
        end else if (r_cnt[b] == CW'(DEB - 1)) begin
          r_filt[b] <= r_sync2[b];
          r_cnt[b]  <= '0;
        end else begin
          r_cnt[b] <= r_cnt[b] + CW'(1);
        end
      end
    end
  end

  assign w_vtrkl_f  = r_filt[NCH-1:0];
  assign w_vterm_f  = r_filt[2*NCH-1:NCH];
  assign w_iterm_f  = r_filt[3*NCH-1:2*NCH];
  assign w_vrchrg_f = r_filt[4*NCH-1:3*NCH];

  // en=0 wins over everything except FAULT; progress wins over timeout.
  function automatic state_t f_next(state_t s, logic en, logic vt, logic vm,
                                    logic it, logic vr, logic tmo, logic clr);
    state_t n;
    n = s;
    if (s != S_FAULT && !en) begin
      n = S_IDLE;
    end else begin
      case (s)
        S_IDLE:   n = S_TRKL;
        S_TRKL:   if (vt) n = S_FAST;   else if (tmo) n = S_FAULT;
        S_FAST:   if (vm) n = S_VCONST; else if (tmo) n = S_FAULT;
        S_VCONST: if (it) n = S_DONE;   else if (tmo) n = S_FAULT;
        S_DONE:   if (vr) n = vt ? S_FAST : S_TRKL;
        S_FAULT:  if (clr) n = S_IDLE;
        default:  n = S_IDLE;
      endcase
    end
    return n;
  endfunction

  // {trkl, fast, vconst, done}
  function automatic logic [3:0] f_ind(state_t s);
    case (s)
      S_TRKL:   return 4'b1000;
      S_FAST:   return 4'b0100;
      S_VCONST: return 4'b0010;
      S_DONE:   return 4'b0001;
      default:  return 4'b0000;
    endcase
  endfunction

`ifndef BCHARGER_NCH_SAFETY_TIMER_EN
  logic w_unused_fclr;
  assign w_unused_fclr = ^bus.fault_clr;
`endif

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_ind;
    logic       w_tmo;
    logic       w_clr;

`ifdef BCHARGER_NCH_SAFETY_TIMER_EN
    logic [TMR_W-1:0] r_tmr;
    logic             r_fault;
    // r_tmr holds the number of edges already spent in the current state.
    assign w_tmo = (r_tmr == TMR_W'(T_MAX - 1));
    assign w_clr = bus.fault_clr[c];
`else
    assign w_tmo = 1'b0;
    assign w_clr = 1'b0;
`endif

    assign w_next = f_next(r_state, bus.en[c], w_vtrkl_f[c], w_vterm_f[c],
                           w_iterm_f[c], w_vrchrg_f[c], w_tmo, w_clr);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_state <= S_IDLE;
        r_ind   <= '0;
`ifdef BCHARGER_NCH_SAFETY_TIMER_EN
        r_tmr   <= '0;
        r_fault <= 1'b0;
`endif
      end else begin
        r_state <= w_next;
        r_ind   <= f_ind(w_next);
`ifdef BCHARGER_NCH_SAFETY_TIMER_EN
        r_fault <= (w_next == S_FAULT);
        if (w_next != r_state)
          r_tmr <= '0;
        else if (r_state == S_TRKL || r_state == S_FAST || r_state == S_VCONST)
          r_tmr <= r_tmr + TMR_W'(1);
`endif
      end
    end

    assign bus.trkl[c]   = r_ind[3];
    assign bus.fast[c]   = r_ind[2];
    assign bus.vconst[c] = r_ind[1];
    assign bus.done[c]   = r_ind[0];
`ifdef BCHARGER_NCH_SAFETY_TIMER_EN
    assign bus.fault[c]  = r_fault;
`else
    assign bus.fault[c]  = 1'b0;
`endif
  end
endmodule
